// File: rtl/roberto_uc.sv
// Control unit for the sensor measure/transmit loop: measures for one interval,
// then sends 4 characters (3 digits + '#') for each of 3 sensors over the serial link.
// Latency: strobes follow the registered state; backpressure: waits indefinitely
// on pronto_seg / pronto_serial, no timeout.
//
// Ports:
//   clock, reset          system clock, asynchronous active-low reset
//   ligar                 run enable, sampled only in INICIAL and FIM_CICLO
//   pronto_seg            measurement interval elapsed (used in ESPERA_MEDIDA only)
//   pronto_serial         transmitter done, level (used in ESPERA_TX only)
//   Q_2, Q_3              sensor index (0..2) and character index (0..3, 3 = '#')
//   zera_*                synchronous clears to the datapath
//   medir, partida_tx, carrega_disc, cont_seg, cont_2, cont_3   datapath strobes
//   pronto                one-cycle end-of-cycle pulse
//   db_estado             current state code
module roberto_uc (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pronto_seg,
  input  logic       pronto_serial,
  input  logic [1:0] Q_2,
  input  logic [1:0] Q_3,
  output logic       zera_sensor,
  output logic       zera_serial,
  output logic       zera_seg,
  output logic       zera_2,
  output logic       zera_3,
  output logic       zera_disc,
  output logic       zera_servos,
  output logic       medir,
  output logic       partida_tx,
  output logic       carrega_disc,
  output logic       cont_seg,
  output logic       cont_2,
  output logic       cont_3,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL       = 4'b0000,
    PREPARA       = 4'b0001,
    MEDE          = 4'b0010,
    ESPERA_MEDIDA = 4'b0011,
    CARREGA       = 4'b0100,
    TRANSMITE     = 4'b0101,
    ESPERA_TX     = 4'b0110,
    PROX_CHAR     = 4'b0111,
    PROX_SENSOR   = 4'b1000,
    FIM_CICLO     = 4'b1001
  } state_t;

  localparam logic [1:0] LAST_CHAR   = 2'd3;
  localparam logic [1:0] LAST_SENSOR = 2'd2;

  state_t state;
  state_t next_state;

  // Index comparisons; Q_2/Q_3 come from registered datapath counters, so these
  // are stable across the whole cycle in which they are used.
  logic last_char;
  logic last_sensor;

  assign last_char   = (Q_3 == LAST_CHAR);
  assign last_sensor = (Q_2 == LAST_SENSOR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= INICIAL;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = INICIAL;
    zera_sensor  = 1'b0;
    zera_serial  = 1'b0;
    zera_seg     = 1'b0;
    zera_2       = 1'b0;
    zera_3       = 1'b0;
    zera_disc    = 1'b0;
    zera_servos  = 1'b0;
    medir        = 1'b0;
    partida_tx   = 1'b0;
    carrega_disc = 1'b0;
    cont_seg     = 1'b0;
    cont_2       = 1'b0;
    cont_3       = 1'b0;
    pronto       = 1'b0;

    case (state)
      INICIAL: begin
        next_state = ligar ? PREPARA : INICIAL;
      end

      PREPARA: begin
        zera_sensor = 1'b1;
        zera_serial = 1'b1;
        zera_seg    = 1'b1;
        zera_2      = 1'b1;
        zera_3      = 1'b1;
        zera_disc   = 1'b1;
        zera_servos = 1'b1;
        next_state  = MEDE;
      end

      // Trigger a measurement and restart the interval counter alongside it.
      MEDE: begin
        medir      = 1'b1;
        zera_seg   = 1'b1;
        next_state = ESPERA_MEDIDA;
      end

      ESPERA_MEDIDA: begin
        cont_seg   = 1'b1;
        next_state = pronto_seg ? CARREGA : ESPERA_MEDIDA;
      end

      // Latch the measured digits and point both indices at (0,0).
      CARREGA: begin
        carrega_disc = 1'b1;
        zera_2       = 1'b1;
        zera_3       = 1'b1;
        next_state   = TRANSMITE;
      end

      TRANSMITE: begin
        partida_tx = 1'b1;
        next_state = ESPERA_TX;
      end

      ESPERA_TX: begin
        next_state = pronto_serial ? PROX_CHAR : ESPERA_TX;
      end

      // The index strobes are qualified by the counter value so the character
      // index is never advanced past '#'.
      PROX_CHAR: begin
        if (last_char) begin
          next_state = PROX_SENSOR;
        end else begin
          cont_3     = 1'b1;
          next_state = TRANSMITE;
        end
      end

      PROX_SENSOR: begin
        if (last_sensor) begin
          next_state = FIM_CICLO;
        end else begin
          cont_2     = 1'b1;
          zera_3     = 1'b1;
          next_state = TRANSMITE;
        end
      end

      FIM_CICLO: begin
        pronto     = 1'b1;
        zera_seg   = 1'b1;
        next_state = ligar ? MEDE : INICIAL;
      end

      default: begin
        next_state = INICIAL;
      end
    endcase
  end

  assign db_estado = state;

endmodule

// File: tb/tb_roberto_uc.sv
// Directed bench for roberto_uc: a stimulus table for the state walk, plus
// sequences for the measure wait, mid-cycle reset and full 12-character cycles.
module tb_roberto_uc;

  logic       clock;
  logic       reset;
  logic       ligar;
  logic       pronto_seg;
  logic       pronto_serial;
  logic [1:0] Q_2;
  logic [1:0] Q_3;
  logic       zera_sensor, zera_serial, zera_seg, zera_2, zera_3, zera_disc, zera_servos;
  logic       medir, partida_tx, carrega_disc, cont_seg, cont_2, cont_3, pronto;
  logic [3:0] db_estado;

  roberto_uc dut (
    .clock        (clock),
    .reset        (reset),
    .ligar        (ligar),
    .pronto_seg   (pronto_seg),
    .pronto_serial(pronto_serial),
    .Q_2          (Q_2),
    .Q_3          (Q_3),
    .zera_sensor  (zera_sensor),
    .zera_serial  (zera_serial),
    .zera_seg     (zera_seg),
    .zera_2       (zera_2),
    .zera_3       (zera_3),
    .zera_disc    (zera_disc),
    .zera_servos  (zera_servos),
    .medir        (medir),
    .partida_tx   (partida_tx),
    .carrega_disc (carrega_disc),
    .cont_seg     (cont_seg),
    .cont_2       (cont_2),
    .cont_3       (cont_3),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output bit positions in the packed observation vector.
  localparam logic [13:0] B_ZSENS  = 14'd1 << 13;
  localparam logic [13:0] B_ZSER   = 14'd1 << 12;
  localparam logic [13:0] B_ZSEG   = 14'd1 << 11;
  localparam logic [13:0] B_Z2     = 14'd1 << 10;
  localparam logic [13:0] B_Z3     = 14'd1 << 9;
  localparam logic [13:0] B_ZDISC  = 14'd1 << 8;
  localparam logic [13:0] B_ZSERVO = 14'd1 << 7;
  localparam logic [13:0] B_MEDIR  = 14'd1 << 6;
  localparam logic [13:0] B_PTX    = 14'd1 << 5;
  localparam logic [13:0] B_CDISC  = 14'd1 << 4;
  localparam logic [13:0] B_CSEG   = 14'd1 << 3;
  localparam logic [13:0] B_C2     = 14'd1 << 2;
  localparam logic [13:0] B_C3     = 14'd1 << 1;
  localparam logic [13:0] B_PRONTO = 14'd1 << 0;
  localparam logic [13:0] Z_ALL    = B_ZSENS | B_ZSER | B_ZSEG | B_Z2 | B_Z3 | B_ZDISC | B_ZSERVO;

  logic [13:0] outs;
  assign outs = {zera_sensor, zera_serial, zera_seg, zera_2, zera_3, zera_disc, zera_servos,
                 medir, partida_tx, carrega_disc, cont_seg, cont_2, cont_3, pronto};

  // Datapath index counters, modelled for the full-cycle runs.
  logic       use_model;
  logic [1:0] tbl_q2, tbl_q3;
  logic [1:0] m_q2, m_q3;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q2 <= 2'd0;
      m_q3 <= 2'd0;
    end else begin
      if (zera_2)      m_q2 <= 2'd0;
      else if (cont_2) m_q2 <= m_q2 + 2'd1;
      if (zera_3)      m_q3 <= 2'd0;
      else if (cont_3) m_q3 <= m_q3 + 2'd1;
    end
  end

  assign Q_2 = use_model ? m_q2 : tbl_q2;
  assign Q_3 = use_model ? m_q3 : tbl_q3;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       lig;
    logic       pseg;
    logic       pser;
    logic [1:0] q2;
    logic [1:0] q3;
    logic [3:0] exp_st;
    logic [13:0] exp_out;
  } vec_t;

  vec_t tbl [20];

  // One measure/transmit cycle driven by the counter model; pronto_serial
  // rises 5 cycles after each partida_tx. Optionally drops ligar on a given pulse.
  task automatic run_cycle(input int drop_at, input logic [3:0] exp_after);
    int  n_tx = 0;
    int  gap  = 99;
    bit  done = 1'b0;
    logic [3:0] want;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clock);
      if (partida_tx) begin
        want = {n_tx[3:2], n_tx[1:0]};
        chk($sformatf("tx_order_%0d", n_tx), {m_q2, m_q3}, want);
        n_tx++;
        gap = 0;
        if (n_tx == drop_at) ligar = 1'b0;
      end else begin
        gap++;
      end
      pronto_serial = (gap >= 5);
      if (pronto) begin
        done = 1'b1;
        chk("fim_state", db_estado, 4'b1001);
      end
    end
    chk("cycle_timeout", done, 1);
    chk("tx_count", n_tx, 12);
    @(negedge clock);
    chk("pronto_width", pronto, 0);
    chk("after_fim", db_estado, exp_after);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 4'h1, Z_ALL};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 4'h2, B_MEDIR | B_ZSEG};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 4'h3, B_CSEG};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 4'h3, B_CSEG};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'h4, B_CDISC | B_Z2 | B_Z3};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 4'h5, B_PTX};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 4'h6, 14'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 4'h7, B_C3};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'h5, B_PTX};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 4'h6, 14'd0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 4'h7, 14'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 4'h8, B_C2 | B_Z3};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'h5, B_PTX};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 4'h6, 14'd0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 2'd2, 2'd3, 4'h6, 14'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd3, 4'h7, 14'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 4'h8, 14'd0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 4'h9, B_PRONTO | B_ZSEG};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'h0, 14'd0};
    tbl[19] = '{1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 4'h0, 14'd0};

    use_model     = 1'b0;
    tbl_q2        = 2'd0;
    tbl_q3        = 2'd0;
    reset         = 1'b0;
    ligar         = 1'b1;
    pronto_seg    = 1'b0;
    pronto_serial = 1'b0;

    // Reset held with ligar=1.
    repeat (3) @(negedge clock);
    chk("rst_state", db_estado, 4'h0);
    chk("rst_outs", outs, 14'd0);
    reset = 1'b1;

    // Table walk through every state and both branch conditions.
    for (int i = 0; i < 20; i++) begin
      ligar         = tbl[i].lig;
      pronto_seg    = tbl[i].pseg;
      pronto_serial = tbl[i].pser;
      tbl_q2        = tbl[i].q2;
      tbl_q3        = tbl[i].q3;
      @(negedge clock);
      chk($sformatf("tbl%0d_state", i), db_estado, tbl[i].exp_st);
      chk($sformatf("tbl%0d_outs", i), outs, tbl[i].exp_out);
    end

    // Long measurement wait.
    ligar = 1'b1; pronto_seg = 1'b0; pronto_serial = 1'b0;
    tbl_q2 = 2'd0; tbl_q3 = 2'd0;
    repeat (3) @(negedge clock);
    ligar = 1'b0;
    chk("mw_enter", db_estado, 4'h3);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      chk("mw_cont_seg", cont_seg, 1);
    end
    pronto_seg = 1'b1;
    @(negedge clock);
    pronto_seg = 1'b0;
    chk("mw_carrega", carrega_disc, 1);
    @(negedge clock);
    chk("mw_ptx", partida_tx, 1);
    @(negedge clock);
    chk("mw_no_ptx", partida_tx, 0);
    chk("mr_in_tx_wait", db_estado, 4'h6);

    // Reset mid-transmission, asserted between edges.
    #2 reset = 1'b0;
    #1;
    chk("mr_state", db_estado, 4'h0);
    chk("mr_ptx", partida_tx, 0);
    chk("mr_outs", outs, 14'd0);
    @(negedge clock);
    reset = 1'b1;

    // Full cycles with the counter model: continuous run, then stop mid-cycle.
    use_model  = 1'b1;
    pronto_seg = 1'b1;
    ligar      = 1'b1;
    run_cycle(0, 4'h2);
    run_cycle(5, 4'h0);
    @(negedge clock);
    chk("stop_idle", db_estado, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
